// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and size codes for the memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_W = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_BUSY_I = 2'd3
  } arb_state_t;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, memory-stage and memory-side signal bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              flush;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rd_enable;
  logic [DATA_W-1:0] i_rd_data;
  logic              i_rd_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rd_enable;
  logic [DATA_W-1:0] d_rd_data;
  logic              d_rd_ready;
  logic              d_wr_enable;
  logic [DATA_W-1:0] d_wr_data;
  logic [1:0]        d_wr_size;
  logic              d_wr_full;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [1:0]        mem_wr_size;
  logic              mem_wr_enable;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_ready;

  // Arbiter view: requests and memory responses come in, grants and strobes go out.
  modport slave (
    input  flush,
    input  i_addr, i_rd_enable,
    output i_rd_data, i_rd_ready,
    input  d_addr, d_rd_enable, d_wr_enable, d_wr_data, d_wr_size,
    output d_rd_data, d_rd_ready, d_wr_full,
    output mem_addr, mem_wr_data, mem_wr_size, mem_wr_enable, mem_rd_enable,
    input  mem_rd_data, mem_ready
  );

  // Pipeline plus memory-model view, mirror of the arbiter.
  modport master (
    output flush,
    output i_addr, i_rd_enable,
    input  i_rd_data, i_rd_ready,
    output d_addr, d_rd_enable, d_wr_enable, d_wr_data, d_wr_size,
    input  d_rd_data, d_rd_ready, d_wr_full,
    input  mem_addr, mem_wr_data, mem_wr_size, mem_wr_enable, mem_rd_enable,
    output mem_rd_data, mem_ready
  );

endinterface

// File: rtl/mem_arb_wbuf.sv
// rtl/mem_arb_wbuf.sv - one-entry posted store buffer, captures when empty and clears on drain
module mem_arb_wbuf
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [1:0]        wr_size_i,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        size_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [1:0]        size_q,  size_d;

  // Capture only into an empty slot; a pulse while occupied is dropped.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    if (valid_q) begin
      if (drain_i) valid_d = 1'b0;
    end else if (wr_en_i) begin
      valid_d = 1'b1;
      addr_d  = wr_addr_i;
      data_d  = wr_data_i;
      size_d  = wr_size_i;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= MEM_SZ_BYTE;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign size_o  = size_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and memory stage with a posted store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        wsize_q, wsize_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              drop_d_q, drop_d_d;
  logic              grant_wd;
  logic              grant_i;

  logic              wbuf_valid;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;
  logic [1:0]        wbuf_size;
  logic              wbuf_drain;

  assign wbuf_drain = bus.mem_ready && (state_q == ARB_BUSY_W);

  mem_arb_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.d_wr_enable),
    .wr_addr_i (bus.d_addr),
    .wr_data_i (bus.d_wr_data),
    .wr_size_i (bus.d_wr_size),
    .drain_i   (wbuf_drain),
    .valid_o   (wbuf_valid),
    .addr_o    (wbuf_addr),
    .data_o    (wbuf_data),
    .size_o    (wbuf_size)
  );

  // Arbitration and memory-side register loading; outputs frozen while busy.
  // A D read arriving with a store pulse is held off so the store is buffered and issued first.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wsize_d  = wsize_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    grant_wd = 1'b0;
    grant_i  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (wbuf_valid) begin
          state_d  = ARB_BUSY_W;
          addr_d   = wbuf_addr;
          wdata_d  = wbuf_data;
          wsize_d  = wbuf_size;
          wr_en_d  = 1'b1;
          grant_wd = 1'b1;
        end else if (bus.d_rd_enable && !bus.d_wr_enable &&
                     ((starve_q < STARVE_MAX) || !bus.i_rd_enable)) begin
          state_d  = ARB_BUSY_D;
          addr_d   = bus.d_addr;
          rd_en_d  = 1'b1;
          grant_wd = 1'b1;
        end else if (bus.i_rd_enable) begin
          state_d  = ARB_BUSY_I;
          addr_d   = bus.i_addr;
          rd_en_d  = 1'b1;
          grant_i  = 1'b1;
        end
      end
      default: begin
        if (bus.mem_ready) begin
          state_d = ARB_IDLE;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
        end
      end
    endcase
  end

  // Starvation count of D-side grants while fetch waits, plus the flush drop flag.
  always_comb begin
    starve_d = starve_q;
    if (!bus.i_rd_enable || grant_i) begin
      starve_d = '0;
    end else if (grant_wd && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
    drop_d_d = 1'b0;
    if ((state_q == ARB_BUSY_D) && !bus.mem_ready) begin
      drop_d_d = drop_d_q || bus.flush;
    end
  end

  // State and memory-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wsize_q  <= MEM_SZ_BYTE;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      starve_q <= '0;
      drop_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wsize_q  <= wsize_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      starve_q <= starve_d;
      drop_d_q <= drop_d_d;
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_wr_data   = wdata_q;
  assign bus.mem_wr_size   = wsize_q;
  assign bus.mem_rd_enable = rd_en_q;
  assign bus.mem_wr_enable = wr_en_q;
  assign bus.d_wr_full     = wbuf_valid;
  assign bus.i_rd_data     = bus.mem_rd_data;
  assign bus.d_rd_data     = bus.mem_rd_data;
  assign bus.i_rd_ready    = bus.mem_ready && (state_q == ARB_BUSY_I);
  assign bus.d_rd_ready    = bus.mem_ready && (state_q == ARB_BUSY_D) && !drop_d_q;

  // A store pulse into an occupied buffer would be lost.
  a_no_store_when_full: assert property (@(posedge clk) disable iff (reset)
    !(bus.d_wr_enable && wbuf_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: ready arrives lat cycles after the strobe is first seen.
  logic [31:0] mem_data [logic [31:0]];
  bit          mbusy;
  int          mcnt;
  bit          fire;

  always @(posedge clk) begin
    if (reset) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
      bus.mem_ready   <= 1'b0;
      bus.mem_rd_data <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      fire = 1'b0;
      if (mbusy) begin
        if (mcnt == 1) begin
          mbusy <= 1'b0;
          fire = 1'b1;
        end else begin
          mcnt <= mcnt - 1;
        end
      end else if ((bus.mem_rd_enable || bus.mem_wr_enable) && !bus.mem_ready) begin
        if (lat <= 1) fire = 1'b1;
        else begin
          mbusy <= 1'b1;
          mcnt  <= lat - 1;
        end
      end
      if (fire) begin
        bus.mem_ready <= 1'b1;
        if (bus.mem_wr_enable) mem_data[bus.mem_addr] = bus.mem_wr_data;
        else bus.mem_rd_data <= mem_data.exists(bus.mem_addr) ? mem_data[bus.mem_addr] : 32'h0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lat = 1;
    bus.i_addr = 32'h40;
    bus.i_rd_enable = 1'b1;
    step();
    step();
    total++; if (bus.mem_rd_enable !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", bus.mem_rd_enable); end
    total++; if (bus.mem_wr_enable !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.mem_wr_enable); end
    total++; if ({bus.i_rd_ready, bus.d_rd_ready} !== 2'b00) begin bad++; $display("FAIL reset_readys got=%b exp=00", {bus.i_rd_ready, bus.d_rd_ready}); end
    total++; if (bus.d_wr_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.d_wr_full); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    reset = 1'b0;
    step();
    total++; if (bus.mem_rd_enable !== 1'b1 || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL post_reset_grant got en=%b addr=%h exp en=1 addr=40", bus.mem_rd_enable, bus.mem_addr); end
    step();
    total++; if (bus.i_rd_ready !== 1'b1 || bus.i_rd_data !== 32'h0BADF00D) begin bad++; $display("FAIL post_reset_ready got rdy=%b data=%h exp rdy=1 data=0badf00d", bus.i_rd_ready, bus.i_rd_data); end
    bus.i_rd_enable = 1'b0;
    step();
    total++; if (bus.mem_rd_enable !== 1'b0 || bus.i_rd_ready !== 1'b0) begin bad++; $display("FAIL post_reset_idle got en=%b rdy=%b exp 0 0", bus.mem_rd_enable, bus.i_rd_ready); end
  endtask

  task automatic test_i_read();
    lat = 3;
    bus.i_addr = 32'h100;
    bus.i_rd_enable = 1'b1;
    step();
    total++; if (bus.mem_rd_enable !== 1'b1 || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL i_strobe got en=%b addr=%h exp en=1 addr=100", bus.mem_rd_enable, bus.mem_addr); end
    step();
    step();
    total++; if (bus.i_rd_ready !== 1'b0 || bus.mem_rd_enable !== 1'b1) begin bad++; $display("FAIL i_wait got rdy=%b en=%b exp rdy=0 en=1", bus.i_rd_ready, bus.mem_rd_enable); end
    step();
    total++; if (bus.i_rd_ready !== 1'b1 || bus.i_rd_data !== 32'hDEADBEEF || bus.d_rd_ready !== 1'b0) begin bad++; $display("FAIL i_ready got rdy=%b d_rdy=%b data=%h exp rdy=1 d_rdy=0 data=deadbeef", bus.i_rd_ready, bus.d_rd_ready, bus.i_rd_data); end
    bus.i_rd_enable = 1'b0;
    step();
    total++; if (bus.i_rd_ready !== 1'b0 || bus.mem_rd_enable !== 1'b0) begin bad++; $display("FAIL i_single_pulse got rdy=%b en=%b exp 0 0", bus.i_rd_ready, bus.mem_rd_enable); end
  endtask

  task automatic test_store_load();
    lat = 2;
    mem_data[32'h200] = 32'h0;
    bus.d_addr = 32'h200;
    bus.d_wr_data = 32'h11223344;
    bus.d_wr_size = MEM_SZ_WORD;
    bus.d_wr_enable = 1'b1;
    bus.d_rd_enable = 1'b1;
    step();
    bus.d_wr_enable = 1'b0;
    total++; if (bus.d_wr_full !== 1'b1 || bus.mem_rd_enable !== 1'b0 || bus.mem_wr_enable !== 1'b0) begin bad++; $display("FAIL sl_buffered got full=%b rd=%b wr=%b exp 1 0 0", bus.d_wr_full, bus.mem_rd_enable, bus.mem_wr_enable); end
    step();
    total++; if (bus.mem_wr_enable !== 1'b1 || bus.mem_rd_enable !== 1'b0 || bus.mem_addr !== 32'h200 || bus.mem_wr_data !== 32'h11223344 || bus.mem_wr_size !== 2'b10) begin bad++; $display("FAIL sl_write_issue got wr=%b rd=%b addr=%h data=%h size=%b exp 1 0 200 11223344 10", bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_addr, bus.mem_wr_data, bus.mem_wr_size); end
    step();
    step();
    total++; if (bus.mem_ready !== 1'b1 || bus.d_wr_full !== 1'b1 || bus.d_rd_ready !== 1'b0) begin bad++; $display("FAIL sl_write_done got mem_ready=%b full=%b d_rdy=%b exp 1 1 0", bus.mem_ready, bus.d_wr_full, bus.d_rd_ready); end
    step();
    total++; if (bus.d_wr_full !== 1'b0 || bus.mem_wr_enable !== 1'b0 || bus.mem_rd_enable !== 1'b0) begin bad++; $display("FAIL sl_gap got full=%b wr=%b rd=%b exp 0 0 0", bus.d_wr_full, bus.mem_wr_enable, bus.mem_rd_enable); end
    step();
    total++; if (bus.mem_rd_enable !== 1'b1 || bus.mem_addr !== 32'h200) begin bad++; $display("FAIL sl_load_issue got rd=%b addr=%h exp 1 200", bus.mem_rd_enable, bus.mem_addr); end
    step();
    step();
    total++; if (bus.d_rd_ready !== 1'b1 || bus.d_rd_data !== 32'h11223344) begin bad++; $display("FAIL sl_load_data got rdy=%b data=%h exp 1 11223344", bus.d_rd_ready, bus.d_rd_data); end
    bus.d_rd_enable = 1'b0;
    step();
    total++; if (bus.mem_rd_enable !== 1'b0 || bus.d_rd_ready !== 1'b0) begin bad++; $display("FAIL sl_idle got rd=%b rdy=%b exp 0 0", bus.mem_rd_enable, bus.d_rd_ready); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_order [6];
    logic [31:0] order [8];
    int ng = 0;
    int nr = 0;
    int ni = 0;
    int nd = 0;
    bit prev = 1'b0;
    exp_order = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    lat = 1;
    bus.i_addr = 32'h300;
    bus.d_addr = 32'h400;
    bus.i_rd_enable = 1'b1;
    bus.d_rd_enable = 1'b1;
    for (int c = 0; c < 100 && nr < 6; c++) begin
      step();
      if (bus.mem_rd_enable && !prev && ng < 8) begin
        order[ng] = bus.mem_addr;
        ng++;
      end
      prev = bus.mem_rd_enable;
      if (bus.i_rd_ready) ni++;
      if (bus.d_rd_ready) nd++;
      if (bus.i_rd_ready || bus.d_rd_ready) nr++;
      if (nr == 6) begin
        bus.i_rd_enable = 1'b0;
        bus.d_rd_enable = 1'b0;
      end
    end
    total++; if (nr != 6 || ng != 6) begin bad++; $display("FAIL cont_count got readys=%0d grants=%0d exp 6 6", nr, ng); end
    total++; if (ni != 1 || nd != 5) begin bad++; $display("FAIL cont_split got i=%0d d=%0d exp 1 5", ni, nd); end
    for (int k = 0; k < 6; k++) begin
      total++; if (k < ng && order[k] !== exp_order[k]) begin bad++; $display("FAIL cont_order[%0d] got=%h exp=%h", k, order[k], exp_order[k]); end
    end
    step();
    total++; if (bus.mem_rd_enable !== 1'b0) begin bad++; $display("FAIL cont_idle got rd=%b exp 0", bus.mem_rd_enable); end
  endtask

  task automatic test_flush();
    int dseen = 0;
    lat = 3;
    mem_data[32'h500] = 32'h55AA55AA;
    mem_data[32'h600] = 32'hCAFEF00D;
    bus.d_addr = 32'h500;
    bus.d_rd_enable = 1'b1;
    step();
    total++; if (bus.mem_rd_enable !== 1'b1 || bus.mem_addr !== 32'h500) begin bad++; $display("FAIL fl_issue got rd=%b addr=%h exp 1 500", bus.mem_rd_enable, bus.mem_addr); end
    bus.flush = 1'b1;
    bus.d_rd_enable = 1'b0;
    bus.i_addr = 32'h600;
    bus.i_rd_enable = 1'b1;
    step();
    bus.flush = 1'b0;
    if (bus.d_rd_ready) dseen++;
    step();
    if (bus.d_rd_ready) dseen++;
    step();
    if (bus.d_rd_ready) dseen++;
    total++; if (bus.mem_ready !== 1'b1 || dseen != 0) begin bad++; $display("FAIL fl_suppressed got mem_ready=%b d_pulses=%0d exp 1 0", bus.mem_ready, dseen); end
    step();
    total++; if (bus.mem_rd_enable !== 1'b0) begin bad++; $display("FAIL fl_idle got rd=%b exp 0", bus.mem_rd_enable); end
    step();
    total++; if (bus.mem_rd_enable !== 1'b1 || bus.mem_addr !== 32'h600) begin bad++; $display("FAIL fl_i_issue got rd=%b addr=%h exp 1 600", bus.mem_rd_enable, bus.mem_addr); end
    step();
    step();
    step();
    total++; if (bus.i_rd_ready !== 1'b1 || bus.i_rd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL fl_i_data got rdy=%b data=%h exp 1 cafef00d", bus.i_rd_ready, bus.i_rd_data); end
    bus.i_rd_enable = 1'b0;
    step();
    lat = 1;
    bus.d_rd_enable = 1'b1;
    step();
    step();
    total++; if (bus.d_rd_ready !== 1'b1 || bus.d_rd_data !== 32'h55AA55AA) begin bad++; $display("FAIL fl_next_d got rdy=%b data=%h exp 1 55aa55aa", bus.d_rd_ready, bus.d_rd_data); end
    bus.d_rd_enable = 1'b0;
    step();
  endtask

  task automatic test_full();
    int zeros = 0;
    int waited = 0;
    lat = 5;
    bus.d_addr = 32'h700;
    bus.d_wr_data = 32'hA1A2A3A4;
    bus.d_wr_size = MEM_SZ_BYTE;
    bus.d_wr_enable = 1'b1;
    step();
    bus.d_wr_enable = 1'b0;
    total++; if (bus.d_wr_full !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp 1", bus.d_wr_full); end
    step();
    total++; if (bus.mem_wr_enable !== 1'b1 || bus.mem_wr_data !== 32'hA1A2A3A4 || bus.mem_wr_size !== 2'b00) begin bad++; $display("FAIL full_w1_issue got wr=%b data=%h size=%b exp 1 a1a2a3a4 00", bus.mem_wr_enable, bus.mem_wr_data, bus.mem_wr_size); end
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.d_wr_full !== 1'b1) zeros++;
    end
    total++; if (bus.mem_ready !== 1'b1 || zeros != 0) begin bad++; $display("FAIL full_held got mem_ready=%b early_clears=%0d exp 1 0", bus.mem_ready, zeros); end
    step();
    total++; if (bus.d_wr_full !== 1'b0) begin bad++; $display("FAIL full_clear got=%b exp 0", bus.d_wr_full); end
    bus.d_addr = 32'h704;
    bus.d_wr_data = 32'hB1B2B3B4;
    bus.d_wr_size = MEM_SZ_HALF;
    bus.d_wr_enable = 1'b1;
    step();
    bus.d_wr_enable = 1'b0;
    step();
    total++; if (bus.mem_wr_enable !== 1'b1 || bus.mem_addr !== 32'h704 || bus.mem_wr_data !== 32'hB1B2B3B4 || bus.mem_wr_size !== 2'b01) begin bad++; $display("FAIL full_w2_issue got wr=%b addr=%h data=%h size=%b exp 1 704 b1b2b3b4 01", bus.mem_wr_enable, bus.mem_addr, bus.mem_wr_data, bus.mem_wr_size); end
    while (bus.d_wr_full && waited < 20) begin
      step();
      waited++;
    end
    total++; if (waited != 6) begin bad++; $display("FAIL full_w2_drain got cycles=%0d exp 6", waited); end
    total++; if (mem_data[32'h700] !== 32'hA1A2A3A4 || mem_data[32'h704] !== 32'hB1B2B3B4) begin bad++; $display("FAIL full_mem got m700=%h m704=%h exp a1a2a3a4 b1b2b3b4", mem_data[32'h700], mem_data[32'h704]); end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.i_addr = '0;
    bus.i_rd_enable = 1'b0;
    bus.d_addr = '0;
    bus.d_rd_enable = 1'b0;
    bus.d_wr_enable = 1'b0;
    bus.d_wr_data = '0;
    bus.d_wr_size = MEM_SZ_BYTE;
    reset = 1'b1;
    mem_data[32'h40]  = 32'h0BADF00D;
    mem_data[32'h100] = 32'hDEADBEEF;
    mem_data[32'h300] = 32'h33333333;
    mem_data[32'h400] = 32'h44444444;
    test_reset();
    test_i_read();
    test_store_load();
    test_contention();
    test_flush();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
